// File: rtl/lane_scroller_pkg.sv
// Shared game constants and the lane FSM state type.
package lane_scroller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    REQ,
    WAIT_DONE,
    UPDATE
  } lane_state_t;

  localparam logic [7:0] DEFAULT_LANE_X = 8'd40;
  localparam logic [8:0] SCREEN_Y_LIMIT = 9'd240;

  // Evaluated 10 bits wide so y + step cannot overflow before the compare.
  function automatic logic step_wraps(input logic [8:0] y,
                                      input logic [8:0] step,
                                      input logic [8:0] limit);
    return ({1'b0, y} + {1'b0, step}) >= {1'b0, limit};
  endfunction

endpackage

// File: rtl/lane_scroller_ticker.sv
// Frame divider: counts 0..FRAME_DIV-1 while enabled, held at 0 otherwise.
module frame_ticker #(
  parameter logic [19:0] FRAME_DIV = 20'd833333
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  logic [19:0] count;

  always_ff @(posedge clock) begin
    if (!reset || !enable) begin
      count <= '0;
    end else if (count == FRAME_DIV - 20'd1) begin
      count <= '0;
    end else begin
      count <= count + 20'd1;
    end
  end

  assign tick = enable && (count == FRAME_DIV - 20'd1);

endmodule

// File: rtl/lane_scroller.sv
// One rhythm-game lane: scrolls a note down once per frame, handshakes redraws, scores hits/misses.
module lane_scroller
  import lane_scroller_pkg::*;
#(
  parameter logic [7:0]  LANE_X    = DEFAULT_LANE_X,
  parameter logic [8:0]  Y_LIMIT   = SCREEN_Y_LIMIT,
  parameter logic [8:0]  STEP      = 9'd4,
  parameter logic [8:0]  HIT_Y_LO  = 9'd200,
  parameter logic [19:0] FRAME_DIV = 20'd833333
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       all_done,
  input  logic       hit,
  output logic       startdraw,
  output logic [7:0] draw_x,
  output logic [8:0] draw_y,
  output logic [7:0] erase_x,
  output logic [8:0] erase_y,
  output logic       note_hit,
  output logic       note_missed
);

  lane_state_t state, next_state;
  logic        tick;
  logic        hit_pending;
  logic        hit_accept;
  logic        wraps;

  frame_ticker #(.FRAME_DIV(FRAME_DIV)) u_ticker (
    .clock  (clock),
    .reset  (reset),
    .enable (state != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    startdraw  = 1'b0;
    case (state)
      IDLE:      if (start) next_state = WAIT_TICK;
      WAIT_TICK: begin
        if (!start)    next_state = IDLE;
        else if (tick) next_state = REQ;
      end
      REQ: begin
        startdraw  = 1'b1;
        next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        startdraw = 1'b1;
        if (all_done) next_state = UPDATE;
      end
      UPDATE:    next_state = WAIT_TICK;
      default:   next_state = IDLE;
    endcase
  end

  assign hit_accept = hit && (state != IDLE) && !hit_pending &&
                      (draw_y >= HIT_Y_LO) && (draw_y < Y_LIMIT);
  assign wraps      = step_wraps(draw_y, STEP, Y_LIMIT);

  // A hit landing in the UPDATE cycle itself is scored and resets the note immediately.
  always_ff @(posedge clock) begin
    if (!reset) begin
      draw_y      <= '0;
      erase_y     <= '0;
      hit_pending <= 1'b0;
      note_hit    <= 1'b0;
      note_missed <= 1'b0;
    end else begin
      note_hit    <= hit_accept;
      note_missed <= 1'b0;
      if (hit_accept) hit_pending <= 1'b1;
      if (state == UPDATE) begin
        erase_y     <= draw_y;
        hit_pending <= 1'b0;
        if (hit_pending || hit_accept) begin
          draw_y <= '0;
        end else if (wraps) begin
          draw_y      <= '0;
          note_missed <= 1'b1;
        end else begin
          draw_y <= draw_y + STEP;
        end
      end
    end
  end

  assign draw_x  = LANE_X;
  assign erase_x = LANE_X;

endmodule

// File: tb/tb_lane_scroller.sv
// Randomized bench for lane_scroller against a frame/handshake-level reference model.
module tb_lane_scroller;

  localparam logic [7:0]  LX = 8'd40;
  localparam int          YL = 16;
  localparam int          ST = 4;
  localparam int          HL = 8;
  localparam int          FD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       all_done = 1'b0;
  logic       hit = 1'b0;
  logic       startdraw;
  logic [7:0] draw_x;
  logic [8:0] draw_y;
  logic [7:0] erase_x;
  logic [8:0] erase_y;
  logic       note_hit;
  logic       note_missed;

  always #5 clock = ~clock;

  lane_scroller #(
    .LANE_X   (LX),
    .Y_LIMIT  (9'(YL)),
    .STEP     (9'(ST)),
    .HIT_Y_LO (9'(HL)),
    .FRAME_DIV(20'(FD))
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .all_done   (all_done),
    .hit        (hit),
    .startdraw  (startdraw),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .erase_x    (erase_x),
    .erase_y    (erase_y),
    .note_hit   (note_hit),
    .note_missed(note_missed)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: game running flag, cycles since start (frame phase), age of the
  // outstanding draw request, and the note position as plain integers.
  bit m_run = 0;
  int m_since = 0;
  int m_req_age = -1;
  bit m_upd = 0;
  int m_y = 0;
  int m_prev = 0;
  bit m_pend = 0;
  bit m_nh = 0;
  bit m_nm = 0;

  task automatic model_step(input bit r, input bit s, input bit dn, input bit h);
    bit frame_due;
    bit took;
    if (!r) begin
      m_run = 0; m_since = 0; m_req_age = -1; m_upd = 0;
      m_y = 0; m_prev = 0; m_pend = 0; m_nh = 0; m_nm = 0;
      return;
    end
    frame_due = m_run && (m_since % FD == FD - 1);
    took = h && m_run && !m_pend && (m_y >= HL) && (m_y < YL);
    m_nh = took;
    m_nm = 0;
    if (m_upd) begin
      m_prev = m_y;
      if (m_pend || took)     m_y = 0;
      else if (m_y + ST >= YL) begin m_y = 0; m_nm = 1; end
      else                     m_y = m_y + ST;
      m_pend = 0;
      m_upd = 0;
      m_since++;
    end else if (m_req_age >= 0) begin
      if (took) m_pend = 1;
      if (m_req_age >= 1 && dn) begin m_req_age = -1; m_upd = 1; end
      else m_req_age++;
      m_since++;
    end else if (m_run) begin
      if (took) m_pend = 1;
      if (!s)             m_run = 0;
      else if (frame_due) m_req_age = 0;
      m_since++;
    end else if (s) begin
      m_run = 1;
      m_since = 0;
    end
  endtask

  // Display-controller stand-in: all_done follows startdraw two cycles late.
  bit sd_h1 = 0;
  bit sd_h2 = 0;

  task automatic run_cycle(input bit r, input bit s, input bit h, input bit stall);
    reset    = r;
    start    = s;
    hit      = h;
    all_done = sd_h1 && sd_h2 && !stall;
    @(posedge clock);
    model_step(r, s, all_done, h);
    @(negedge clock);
    check("startdraw",   startdraw,   (m_req_age >= 0) ? 1 : 0);
    check("draw_y",      draw_y,      m_y);
    check("erase_y",     erase_y,     m_prev);
    check("note_hit",    note_hit,    m_nh);
    check("note_missed", note_missed, m_nm);
    check("draw_x",      draw_x,      LX);
    check("erase_x",     erase_x,     LX);
    sd_h2 = sd_h1;
    sd_h1 = startdraw;
  endtask

  task automatic wait_request();
    int n = 0;
    while (!startdraw && n < 20) begin
      run_cycle(1, 1, 0, 0);
      n++;
    end
    check("req_seen", startdraw, 1);
  endtask

  initial begin
    int lat;
    int stall_left;
    bit s, h, r, st;
    @(negedge clock);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 1, 1, 0);

    // Request appears FRAME_DIV cycles after the edge that samples start.
    lat = 0;
    do begin
      run_cycle(1, 1, 0, 0);
      lat++;
    end while (!startdraw && lat < 20);
    check("rise_lat", lat, FD + 1);

    repeat (40) run_cycle(1, 1, 0, 0);

    // Long all_done stall, then reset in the middle of the handshake.
    wait_request();
    repeat (10) run_cycle(1, 1, 0, 1);
    check("stall_hold", startdraw, 1);
    run_cycle(0, 1, 0, 1);
    check("reset_mid", startdraw, 0);

    // Hits attempted at every position, including a double hit in one frame.
    for (int k = 0; k < 12; k++) begin
      wait_request();
      run_cycle(1, 1, 1, 0);
      run_cycle(1, 1, (k % 3) == 0, 0);
      repeat (3) run_cycle(1, 1, 0, 0);
    end

    stall_left = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(199) != 0);
      s = ($urandom_range(39) != 0);
      h = ($urandom_range(5) == 0);
      if (stall_left == 0 && $urandom_range(39) == 0) stall_left = 10;
      if (stall_left > 0) begin
        st = 1;
        stall_left--;
      end else begin
        st = ($urandom_range(3) == 0);
      end
      run_cycle(r, s, h, st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_scroller.md
LANE_SCROLLER -- requirements
Module: lane_scroller

Interface
REQ-001 Parameter LANE_X, default 8'd40, fixed x coordinate of the lane's note block.
REQ-002 Parameter Y_LIMIT, default 9'd240, first y value that is off-screen.
REQ-003 Parameter STEP, default 9'd4, pixels the note descends per frame.
REQ-004 Parameter HIT_Y_LO, default 9'd200, lowest y (inclusive) of the hit window.
REQ-005 Parameter FRAME_DIV, default 20'd833333, clock cycles per frame (60 Hz at 50 MHz).
REQ-006 clock  in  1  system clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 start  in  1  level; 1 = game running.
REQ-009 all_done  in  1  display_controller finished erase+draw for the current request.
REQ-010 hit  in  1  single-cycle player keypress for this lane.
REQ-011 startdraw  out  1  draw request to display_controller (level).
REQ-012 draw_x  out  8  x of note to draw; always LANE_X.
REQ-013 draw_y  out  9  y of note to draw.
REQ-014 erase_x  out  8  x of note to erase; always LANE_X.
REQ-015 erase_y  out  9  y of previous note position to erase.
REQ-016 note_hit  out  1  one-cycle pulse, successful hit; drives score addscore.
REQ-017 note_missed  out  1  one-cycle pulse, note left screen unhit.

Function
REQ-018 States SHALL be IDLE, WAIT_TICK, REQ, WAIT_DONE, UPDATE.
REQ-019 IDLE -> WAIT_TICK when start=1; frame counter cleared to 0 on this transition.
REQ-020 Frame counter SHALL count 0..FRAME_DIV-1 and wrap; tick = counter at FRAME_DIV-1, outside IDLE only.
REQ-021 WAIT_TICK -> REQ on tick; ticks arriving in REQ/WAIT_DONE/UPDATE are dropped, not queued.
REQ-022 startdraw SHALL be 1 exactly in REQ and WAIT_DONE; REQ -> WAIT_DONE unconditionally after one cycle.
REQ-023 WAIT_DONE -> UPDATE on all_done=1; startdraw deasserts on that same edge, so display_controller leaves DONE.
REQ-024 draw_y/erase_y SHALL be stable whenever startdraw=1.
REQ-025 UPDATE lasts one cycle: erase_y <= draw_y, then draw_y updated per REQ-026..028, then -> WAIT_TICK.
REQ-026 Normal step: draw_y <= draw_y + STEP, computed 10 bits wide to avoid overflow.
REQ-027 Wrap: if draw_y + STEP >= Y_LIMIT, draw_y <= 0 and note_missed pulses in the cycle after UPDATE.
REQ-028 hit while HIT_Y_LO <= draw_y < Y_LIMIT sets hit_pending and pulses note_hit next cycle; at UPDATE hit_pending forces draw_y <= 0, clears hit_pending, no note_missed.
REQ-029 Only the first in-window hit per frame counts; hits while hit_pending=1 or outside window are ignored.
REQ-030 Hit and wrap in same UPDATE: hit wins, note_missed stays 0.
REQ-031 start=0 in WAIT_TICK -> IDLE with positions held; start=0 in REQ/WAIT_DONE/UPDATE completes the handshake first.
REQ-032 hit in IDLE SHALL be ignored.

Reset
REQ-033 reset=0 at a clock edge: state IDLE, counter 0, draw_y 0, erase_y 0, hit_pending 0, startdraw 0, note_hit 0, note_missed 0; reset overrides all, including mid-handshake.
REQ-034 draw_x and erase_x SHALL equal LANE_X in and out of reset.

Structure
REQ-035 State encodings and screen constants (Y_LIMIT, default LANE_X) SHALL live in the shared game package.
REQ-036 Frame divider SHALL be a separate sub-module frame_ticker (inputs clock, reset, enable; output tick).

Verification (FRAME_DIV=4, STEP=4, Y_LIMIT=16, HIT_Y_LO=8)
REQ-037 Reset, start=1, all_done tied to startdraw with 2-cycle delay -> startdraw rises 4 cycles after start; draw_y sequence 4,8,12 on successive UPDATEs; erase_y lags one frame.
REQ-038 Let draw_y reach 12, no hit -> next UPDATE draw_y=0, erase_y=12, note_missed one-cycle pulse.
REQ-039 hit at draw_y=8 -> note_hit pulse next cycle; next UPDATE draw_y=0, no note_missed; second hit same frame -> no pulse.
REQ-040 hit at draw_y=4 -> no note_hit, draw_y steps to 8 normally.
REQ-041 Hold all_done=0 for 10 cycles -> startdraw stays 1, draw_y unchanged, no new request; extra ticks dropped.
REQ-042 reset=0 during WAIT_DONE -> next edge startdraw=0, state IDLE, draw_y=0, erase_y=0.
